// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath word, write mask, and the data-memory
// responder's state encoding and default latency.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmr_state_t;

  localparam int DMR_DEFAULT_LATENCY = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory port between the MEM stage (master) and the memory responder (slave).
interface data_mem_responder_if;
  import lc3b_types::*;

  lc3b_word      mem_address;
  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;
  logic          mem_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// DEPTH_WORDS x 16 word array: synchronous byte-masked write, combinational read,
// plus a preload task that benches call hierarchically.
module dmem_array
  import lc3b_types::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  lc3b_mem_wmask wmask,
  input  logic [AW-1:0] addr,
  input  lc3b_word      wdata,
  output lc3b_word      rdata
);

  lc3b_word mem [DEPTH_WORDS];

  // NOTE: the array has no reset; contents are undefined until written or preloaded.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[addr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[addr];

  task automatic preload(input int unsigned idx, input lc3b_word data);
    mem[idx[AW-1:0]] <= data;
  endtask

endmodule

// File: rtl/data_mem_responder.sv
// Cycle-accurate data-cache stand-in: accepts one request, waits LATENCY cycles,
// performs the access, then pulses mem_resp for one cycle.
module data_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY     = DMR_DEFAULT_LATENCY,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if ((1 << AW) != DEPTH_WORDS) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_WORDS must be a power of two");
  end

  dmr_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx_q;
  lc3b_word      wdata_q, rdata_q, arr_rdata;
  lc3b_mem_wmask be_q;
  logic          write_q, err_q;
  logic          req, accept, do_access;

  // Byte-address bit 0 and bits above the array depth are don't-cares.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_address[15:AW+1], bus.mem_address[0]};

  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        cnt_n   = CW'(LATENCY - 1);
        state_n = BUSY;
      end
      // Dropping both request lines while waiting aborts with no side effects.
      BUSY: if (!req) begin
        state_n = IDLE;
      end else if (cnt == '0) begin
        do_access = 1'b1;
        state_n   = RESP;
      end else begin
        cnt_n = cnt - CW'(1);
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q   <= bus.mem_address[AW:1];
        wdata_q <= bus.mem_wdata;
        be_q    <= bus.mem_byte_enable;
        write_q <= bus.mem_write;
        if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
      end
      if (do_access && !write_q) rdata_q <= arr_rdata;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (do_access & write_q),
    .wmask (be_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.mem_resp  = (state == RESP);
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default-latency instance for the
// functional cases, LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if fbus ();

  data_mem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave)
  );
  data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_fast (
    .clk (clk), .rst_n (rst_n), .bus (fbus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    fbus.mem_read = 1'b0; fbus.mem_write = 1'b0; fbus.mem_address = '0;
    fbus.mem_byte_enable = '0; fbus.mem_wdata = '0;
  endtask

  // Issue one request on the default instance starting in cycle 0, wait for the
  // response, then drop the request and confirm the pulse lasted one cycle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] wd);
    int resp_cycle = -1;
    @(posedge clk); #1;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        resp_cycle = c;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_resp_cycle"}, resp_cycle, 5);
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    check({tag, "_single_pulse"}, bus.mem_resp, 1'b0);
    check({tag, "_back_idle"}, u_dut.state, IDLE);
  endtask

  initial begin
    int n_resp;
    idle_bus();

    // Reset held three cycles with no requests
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", bus.mem_resp, 1'b0);
    check("rst_rdata", bus.mem_rdata, 16'h0000);
    check("rst_err", bus.mem_err, 1'b0);
    check("rst_state", u_dut.state, IDLE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_resp", bus.mem_resp, 1'b0);
    check("idle_state", u_dut.state, IDLE);

    // Write then read
    access("wr_beef", 1'b0, 1'b1, 16'h0040, 2'b11, 16'hBEEF);
    check("wr_beef_err", bus.mem_err, 1'b0);
    access("rd_beef", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    check("rd_beef_data", bus.mem_rdata, 16'hBEEF);

    // Byte masking on a preloaded word
    @(posedge clk); #1;
    u_dut.u_array.preload(32'h8, 16'h1234);
    access("wr_hi", 1'b0, 1'b1, 16'h0010, 2'b10, 16'hABCD);
    access("rd_hi", 1'b1, 1'b0, 16'h0010, 2'b11, 16'h0000);
    check("rd_hi_data", bus.mem_rdata, 16'hAB34);
    access("wr_none", 1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF);
    access("rd_none", 1'b1, 1'b0, 16'h0011, 2'b00, 16'h0000);
    check("rd_none_data", bus.mem_rdata, 16'hAB34);

    // Abort: read of a different word dropped in BUSY cycle 2
    @(posedge clk); #1;
    bus.mem_read = 1'b1; bus.mem_address = 16'h0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("abort_state_c2", u_dut.state, BUSY);
    n_resp = 0;
    for (int c = 3; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) check("abort_idle_c3", u_dut.state, IDLE);
      if (bus.mem_resp) n_resp++;
    end
    check("abort_no_resp", n_resp, 0);
    check("abort_rdata_kept", bus.mem_rdata, 16'hAB34);

    // Read/write conflict: write wins, error is sticky
    @(posedge clk); #1;
    bus.mem_byte_enable = 2'b11;
    access("conflict", 1'b1, 1'b1, 16'h0030, 2'b11, 16'h5555);
    check("conflict_err", bus.mem_err, 1'b1);
    access("rd_conflict", 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0000);
    check("rd_conflict_data", bus.mem_rdata, 16'h5555);
    check("err_sticky", bus.mem_err, 1'b1);

    // Reset mid-BUSY drops an uncommitted write
    @(posedge clk); #1;
    u_dut.u_array.preload(32'h10, 16'h2222);
    @(posedge clk); #1;
    bus.mem_write = 1'b1; bus.mem_address = 16'h0020;
    bus.mem_byte_enable = 2'b11; bus.mem_wdata = 16'h9999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_state", u_dut.state, IDLE);
    check("midrst_resp", bus.mem_resp, 1'b0);
    check("midrst_err_clr", bus.mem_err, 1'b0);
    bus.mem_write = 1'b0;
    n_resp = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_resp) n_resp++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_resp) n_resp++;
    end
    check("midrst_no_resp", n_resp, 0);
    access("rd_2222", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000);
    check("rd_2222_data", bus.mem_rdata, 16'h2222);

    // LATENCY=1 back-to-back: read held continuously, resp in cycles 2,5,8
    @(posedge clk); #1;
    u_fast.u_array.preload(32'h20, 16'hC0DE);
    @(posedge clk); #1;
    fbus.mem_read = 1'b1; fbus.mem_address = 16'h0040;
    n_resp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("fast_resp_c%0d", c), fbus.mem_resp, (c % 3) == 2);
      if (fbus.mem_resp) n_resp++;
      @(posedge clk); #1;
    end
    fbus.mem_read = 1'b0;
    check("fast_pulse_count", n_resp, 3);
    check("fast_rdata", fbus.mem_rdata, 16'hC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
